// File: rtl/can_mem_arbiter.sv
// Shares the 256x8 read/write/CAM memory between the host interface and the CAN core.
// Each access runs IDLE -> ISSUE -> CAPTURE, with req/gnt/done handshakes per requester.
module can_mem_arbiter #(
  parameter bit RR = 1'b1,
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_req,
  input  logic [1:0]    h_op,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_done,
  output logic [DW-1:0] h_rdata,
  input  logic          c_req,
  input  logic [1:0]    c_op,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  output logic          mem_rw,
  output logic          mem_search,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_SRCH = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t        state_q, state_d;
  logic          win_c_q, win_c_d;
  logic          last_c_q, last_c_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          h_gnt_q, h_gnt_d, c_gnt_q, c_gnt_d;
  logic          h_done_q, h_done_d, c_done_q, c_done_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d, c_rdata_q, c_rdata_d;
  logic          pick_c;
  logic [DW-1:0] cap_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      win_c_q   <= 1'b0;
      last_c_q  <= 1'b0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      din_q     <= '0;
      h_gnt_q   <= 1'b0;
      c_gnt_q   <= 1'b0;
      h_done_q  <= 1'b0;
      c_done_q  <= 1'b0;
      h_rdata_q <= '0;
      c_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_c_q   <= win_c_d;
      last_c_q  <= last_c_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      h_gnt_q   <= h_gnt_d;
      c_gnt_q   <= c_gnt_d;
      h_done_q  <= h_done_d;
      c_done_q  <= c_done_d;
      h_rdata_q <= h_rdata_d;
      c_rdata_q <= c_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_c_d   = win_c_q;
    last_c_d  = last_c_q;
    op_d      = op_q;
    addr_d    = addr_q;
    din_d     = din_q;
    h_gnt_d   = 1'b0;
    c_gnt_d   = 1'b0;
    h_done_d  = 1'b0;
    c_done_d  = 1'b0;
    h_rdata_d = h_rdata_q;
    c_rdata_d = c_rdata_q;
    pick_c    = 1'b0;
    cap_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (h_req || c_req) begin
          // On a tie, round-robin favours whoever did not win last; otherwise CAN wins.
          pick_c   = c_req && (!h_req || !RR || !last_c_q);
          win_c_d  = pick_c;
          last_c_d = pick_c;
          op_d     = pick_c ? c_op    : h_op;
          addr_d   = pick_c ? c_addr  : h_addr;
          din_d    = pick_c ? c_wdata : h_wdata;
          c_gnt_d  = pick_c;
          h_gnt_d  = !pick_c;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (win_c_q) cap_data = c_rdata_q;
        else         cap_data = h_rdata_q;
        if (op_q == OP_RD || op_q == OP_SRCH) cap_data = mem_dout;
        else if (op_q == OP_RSV)              cap_data = '0;
        if (win_c_q) begin
          c_rdata_d = cap_data;
          c_done_d  = 1'b1;
        end else begin
          h_rdata_d = cap_data;
          h_done_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes decode from the registered state, so an async reset idles them at once.
  assign mem_rw     = !((state_q == S_ISSUE) && (op_q == OP_WR));
  assign mem_search = (state_q == S_ISSUE) && (op_q == OP_SRCH);
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;

  assign h_gnt   = h_gnt_q;
  assign c_gnt   = c_gnt_q;
  assign h_done  = h_done_q;
  assign c_done  = c_done_q;
  assign h_rdata = h_rdata_q;
  assign c_rdata = c_rdata_q;

endmodule

// File: tb/tb_can_mem_arbiter.sv
// Directed bench for can_mem_arbiter: one round-robin and one fixed-priority instance,
// each attached to a behavioural 256x8 read/write/CAM memory with registered Dout.
module tb_can_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       h_req, c_req;
  logic [1:0] h_op, c_op;
  logic [7:0] h_addr, h_wdata, c_addr, c_wdata;

  logic       h_gnt0, h_done0, c_gnt0, c_done0, m_rw0, m_srch0;
  logic [7:0] h_rdata0, c_rdata0, m_addr0, m_din0, m_dout0;
  logic       h_gnt1, h_done1, c_gnt1, c_done1, m_rw1, m_srch1;
  logic [7:0] h_rdata1, c_rdata1, m_addr1, m_din1, m_dout1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] sres0, sres1;

  int passed = 0, total = 0, fails = 0, inv_bad = 0;
  logic prev_rw0 = 1'b1, prev_rw1 = 1'b1;

  always #5 clk = ~clk;

  can_mem_arbiter #(.RR(1'b1), .AW(8), .DW(8)) u0 (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_op(h_op), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt0), .h_done(h_done0), .h_rdata(h_rdata0),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt0), .c_done(c_done0), .c_rdata(c_rdata0),
    .mem_rw(m_rw0), .mem_search(m_srch0), .mem_addr(m_addr0),
    .mem_din(m_din0), .mem_dout(m_dout0)
  );

  can_mem_arbiter #(.RR(1'b0), .AW(8), .DW(8)) u1 (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_op(h_op), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt1), .h_done(h_done1), .h_rdata(h_rdata1),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_done(c_done1), .c_rdata(c_rdata1),
    .mem_rw(m_rw1), .mem_search(m_srch1), .mem_addr(m_addr1),
    .mem_din(m_din1), .mem_dout(m_dout1)
  );

  // Memory models: contents preloaded on the first edge, lowest matching address on search.
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) begin
        mem0[k] = 8'h00;
        mem1[k] = 8'h00;
      end
      mem0[8'h10] = 8'hAA; mem1[8'h10] = 8'hAA;
      mem0[8'h3C] = 8'hEE; mem1[8'h3C] = 8'hEE;
      loaded = 1'b1;
    end
    if (!m_rw0) mem0[m_addr0] = m_din0;
    if (m_srch0) begin
      sres0 = 8'hFF;
      for (int k = 255; k >= 0; k--) if (mem0[k] == m_din0) sres0 = k[7:0];
      m_dout0 <= sres0;
    end else m_dout0 <= mem0[m_addr0];
    if (!m_rw1) mem1[m_addr1] = m_din1;
    if (m_srch1) begin
      sres1 = 8'hFF;
      for (int k = 255; k >= 0; k--) if (mem1[k] == m_din1) sres1 = k[7:0];
      m_dout1 <= sres1;
    end else m_dout1 <= mem1[m_addr1];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!m_rw0 && m_srch0) inv_bad++;
      if (!m_rw1 && m_srch1) inv_bad++;
      if (!m_rw0 && !prev_rw0) inv_bad++;
      if (!m_rw1 && !prev_rw1) inv_bad++;
      if (h_gnt0 && c_gnt0) inv_bad++;
      if (h_gnt1 && c_gnt1) inv_bad++;
      if (h_done0 && c_done0) inv_bad++;
      if (h_done1 && c_done1) inv_bad++;
    end
    prev_rw0 = m_rw0;
    prev_rw1 = m_rw1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full single-requester access on the round-robin instance, entered just after a falling edge.
  task automatic access(input bit can, input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
    if (can) begin
      c_req = 1'b1; c_op = op; c_addr = addr; c_wdata = wd;
    end else begin
      h_req = 1'b1; h_op = op; h_addr = addr; h_wdata = wd;
    end
    @(negedge clk);
    chk({tag, ".gnt"}, can ? c_gnt0 : h_gnt0, 1);
    chk({tag, ".ogn"}, can ? h_gnt0 : c_gnt0, 0);
    chk({tag, ".rw"}, m_rw0, (op == 2'b01) ? 0 : 1);
    chk({tag, ".srch"}, m_srch0, (op == 2'b10) ? 1 : 0);
    chk({tag, ".addr"}, m_addr0, addr);
    if (op == 2'b01 || op == 2'b10) chk({tag, ".din"}, m_din0, wd);
    h_req = 1'b0;
    c_req = 1'b0;
    @(negedge clk);
    chk({tag, ".rw2"}, m_rw0, 1);
    chk({tag, ".srch2"}, m_srch0, 0);
    chk({tag, ".early"}, can ? c_done0 : h_done0, 0);
    @(negedge clk);
    chk({tag, ".done"}, can ? c_done0 : h_done0, 1);
    chk({tag, ".rdata"}, can ? c_rdata0 : h_rdata0, exp_rd);
    @(negedge clk);
    chk({tag, ".done_end"}, can ? c_done0 : h_done0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    h_req = 1'b1; h_op = 2'b00; h_addr = 8'h55; h_wdata = 8'h00;
    c_req = 1'b1; c_op = 2'b00; c_addr = 8'h10; c_wdata = 8'h00;

    // Reset with both requests pending
    @(negedge clk);
    chk("rst.rw", m_rw0, 1);
    chk("rst.srch", m_srch0, 0);
    chk("rst.gnt", {h_gnt0, c_gnt0, h_gnt1, c_gnt1}, 0);
    chk("rst.done", {h_done0, c_done0}, 0);
    chk("rst.hrd", h_rdata0, 8'h00);
    chk("rst.crd", c_rdata0, 8'h00);
    chk("rst.addr", m_addr0, 8'h00);
    chk("rst.din", m_din0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first.cgnt", c_gnt0, 1);
    chk("first.hgnt", h_gnt0, 0);
    chk("first.cgnt_fp", c_gnt1, 1);
    h_req = 1'b0;
    c_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("first.cdone", c_done0, 1);
    chk("first.crd", c_rdata0, 8'hAA);
    @(negedge clk);

    access(1'b0, 2'b01, 8'h55, 8'h55, 8'h00, "hwr");
    access(1'b0, 2'b00, 8'h55, 8'h00, 8'h55, "hrd");
    access(1'b1, 2'b11, 8'h20, 8'h00, 8'h00, "crsv");
    access(1'b0, 2'b11, 8'h21, 8'h00, 8'h00, "hrsv");

    // Round-robin with both requests held: C, H, C, H
    h_op = 2'b00; h_addr = 8'h55; c_op = 2'b00; c_addr = 8'h10;
    h_req = 1'b1; c_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rr.cgnt%0d", i), c_gnt0, (i == 0 || i == 6) ? 1 : 0);
      chk($sformatf("rr.hgnt%0d", i), h_gnt0, (i == 3 || i == 9) ? 1 : 0);
      chk($sformatf("rr.cdone%0d", i), c_done0, (i == 2 || i == 8) ? 1 : 0);
      chk($sformatf("rr.hdone%0d", i), h_done0, (i == 5 || i == 11) ? 1 : 0);
      if (i == 2) chk("rr.crd", c_rdata0, 8'hAA);
      if (i == 5) chk("rr.hrd", h_rdata0, 8'h55);
      if (i == 9) begin
        h_req = 1'b0;
        c_req = 1'b0;
      end
    end

    // Fixed priority: CAN wins every tie, host only after c_req drops
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    h_req = 1'b1; c_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("fp.cgnt%0d", i), c_gnt1, (i == 0 || i == 3 || i == 6) ? 1 : 0);
      chk($sformatf("fp.hgnt%0d", i), h_gnt1, (i == 9) ? 1 : 0);
      chk($sformatf("fp.cdone%0d", i), c_done1, (i == 2 || i == 5 || i == 8) ? 1 : 0);
      if (i == 2) chk("fp.crd", c_rdata1, 8'hAA);
      if (i == 6) c_req = 1'b0;
      if (i == 9) h_req = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("fp.hdone", h_done1, 1);
    chk("fp.hrd", h_rdata1, 8'h55);
    @(negedge clk);

    access(1'b1, 2'b10, 8'h00, 8'hEE, 8'h3C, "cam");
    chk("cam.keep", mem0[8'h3C], 8'hEE);
    chk("cam.nowr", mem0[8'h00], 8'h00);

    // Reset during the ISSUE cycle of a host write
    h_req = 1'b1; h_op = 2'b01; h_addr = 8'hBB; h_wdata = 8'hBB;
    @(negedge clk);
    chk("abort.gnt", h_gnt0, 1);
    chk("abort.rw_issue", m_rw0, 0);
    h_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort.rw", m_rw0, 1);
    chk("abort.srch", m_srch0, 0);
    chk("abort.gnt0", h_gnt0, 0);
    @(negedge clk);
    chk("abort.done1", h_done0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort.done2", h_done0, 0);
    chk("abort.mem", mem0[8'hBB], 8'h00);
    access(1'b0, 2'b00, 8'hBB, 8'h00, 8'h00, "abort.rd");

    chk("invariants", inv_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
